// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port ram4k block RAM between the CPU and a
// DMA-style requester. The CPU normally wins. The DMA port uses idle cycles.
// After STARVE_LIMIT consecutive denied cycles, the DMA steals one cycle by
// dropping the CPU's RDY. Per-master read-valid strobes follow the RAM's
// one-cycle read latency.
module ram_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 8    // legal range 1..255
) (
  input  logic              clk,
  input  logic              reset,

  // CPU side
  input  logic              cpu_sel,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_rdy,
  output logic              cpu_rvalid,

  // DMA side
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,

  // ram4k side
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  // Saturation point and steal trigger, sized to the 8-bit wait counter.
  localparam logic [7:0] LIMIT    = 8'(STARVE_LIMIT);
  localparam logic [7:0] LIMIT_M1 = 8'(STARVE_LIMIT - 1);

  owner_t     owner;
  logic       steal_r;
  logic [7:0] wait_cnt;
  logic       cpu_rv_r;
  logic       dma_rv_r;
  logic       dma_denied;

  // Pick this cycle's RAM owner. A pending steal overrides the CPU.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first. This way no path can leave it unassigned and infer a latch.
    owner = OWN_NONE;
    if (steal_r)      owner = OWN_DMA;
    else if (cpu_sel) owner = OWN_CPU;
    else if (dma_req) owner = OWN_DMA;
  end

  // The DMA is granted only when it actually asks and owns the cycle. A steal
  // cycle whose request was withdrawn grants nothing.
  assign dma_gnt    = dma_req && (owner == OWN_DMA);
  assign dma_denied = dma_req && !dma_gnt;

  // Steer the winning master onto the RAM port. With no owner, the RAM idles
  // on the CPU address with writes disabled.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = cpu_addr;
    ram_din  = cpu_wdata;
    unique case (owner)
      OWN_CPU: begin
        ram_we   = cpu_we;
        ram_addr = cpu_addr;
        ram_din  = cpu_wdata;
      end
      OWN_DMA: begin
        // Gate with dma_req so a dropped request never writes. The CPU's
        // write is also suppressed here; the CPU retries it after the steal.
        ram_we   = dma_we && dma_req;
        ram_addr = dma_addr;
        ram_din  = dma_wdata;
      end
      default: begin
        ram_we   = 1'b0;
        ram_addr = cpu_addr;
        ram_din  = cpu_wdata;
      end
    endcase
  end

  // Starvation counter, steal flag and read-valid pipeline registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. Every register
    // then samples pre-edge values, whatever order the statements are in.
    if (reset) begin
      steal_r  <= 1'b0;
      wait_cnt <= 8'd0;
      cpu_rv_r <= 1'b0;
      dma_rv_r <= 1'b0;
    end else begin
      if (dma_denied) begin
        if (wait_cnt != LIMIT) wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= 8'd0;
      end

      // One-cycle steal. The stolen cycle grants the DMA, so it can never
      // re-arm itself back-to-back.
      steal_r  <= dma_denied && (wait_cnt == LIMIT_M1);

      cpu_rv_r <= (owner == OWN_CPU) && !cpu_we;
      dma_rv_r <= dma_gnt && !dma_we;
    end
  end

  assign cpu_rdy    = !steal_r;
  assign cpu_rvalid = cpu_rv_r;
  assign dma_rvalid = dma_rv_r;

  // ram_dout passes straight through to both masters. The rvalid strobes say
  // whose data it is, so the arbiter itself never looks at it.
  logic unused_dout;
  assign unused_dout = ^ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed testbench for ram_arbiter with a behavioural ram4k model
// (registered read, one-cycle latency) attached to the RAM port.
module tb_ram_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_sel, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_rdy, cpu_rvalid;
  logic              dma_req, dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt, dma_rvalid;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  int tests_run    = 0;
  int tests_failed = 0;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_sel    (cpu_sel),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdy    (cpu_rdy),
    .cpu_rvalid (cpu_rvalid),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  always #5 clk = ~clk;

  // ram4k model: write on the clock edge, registered read of the old contents.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // Watchdog against any unexpected hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

  // Inputs change 1 time unit after the rising edge. Checks happen at the
  // falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_sel = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (3) next_cycle();
    reset = 1'b0;
    @(negedge clk);
    tests_run++; if (cpu_rdy !== 1'b1) begin tests_failed++; $display("FAIL reset_cpu_rdy: got %b want 1", cpu_rdy); end
    tests_run++; if (cpu_rvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_cpu_rvalid: got %b want 0", cpu_rvalid); end
    tests_run++; if (dma_rvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_dma_rvalid: got %b want 0", dma_rvalid); end
    tests_run++; if (dma_gnt !== 1'b0) begin tests_failed++; $display("FAIL reset_dma_gnt: got %b want 0", dma_gnt); end
    tests_run++; if (ram_we !== 1'b0) begin tests_failed++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
    tests_run++; if (dut.wait_cnt !== 8'd0) begin tests_failed++; $display("FAIL reset_wait_cnt: got %0d want 0", dut.wait_cnt); end
    next_cycle();
  endtask

  task automatic test_dma_only();
    idle_inputs();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 12'h123; dma_wdata = 16'hBEEF;
    @(negedge clk);
    tests_run++; if (dma_gnt !== 1'b1) begin tests_failed++; $display("FAIL dma_wr_gnt: got %b want 1", dma_gnt); end
    tests_run++; if (ram_we !== 1'b1) begin tests_failed++; $display("FAIL dma_wr_ram_we: got %b want 1", ram_we); end
    tests_run++; if (ram_addr !== 12'h123) begin tests_failed++; $display("FAIL dma_wr_addr: got %h want 123", ram_addr); end
    tests_run++; if (ram_din !== 16'hBEEF) begin tests_failed++; $display("FAIL dma_wr_din: got %h want beef", ram_din); end
    tests_run++; if (cpu_rdy !== 1'b1) begin tests_failed++; $display("FAIL dma_wr_cpu_rdy: got %b want 1", cpu_rdy); end
    next_cycle();
    dma_we = 1'b0; dma_wdata = 16'h0000;
    @(negedge clk);
    tests_run++; if (dma_gnt !== 1'b1) begin tests_failed++; $display("FAIL dma_rd_gnt: got %b want 1", dma_gnt); end
    tests_run++; if (ram_we !== 1'b0) begin tests_failed++; $display("FAIL dma_rd_ram_we: got %b want 0", ram_we); end
    tests_run++; if (dma_rvalid !== 1'b0) begin tests_failed++; $display("FAIL dma_wr_no_rvalid: got %b want 0", dma_rvalid); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    tests_run++; if (dma_rvalid !== 1'b1) begin tests_failed++; $display("FAIL dma_rd_rvalid: got %b want 1", dma_rvalid); end
    tests_run++; if (cpu_rvalid !== 1'b0) begin tests_failed++; $display("FAIL dma_rd_cpu_rvalid: got %b want 0", cpu_rvalid); end
    tests_run++; if (ram_dout !== 16'hBEEF) begin tests_failed++; $display("FAIL dma_rd_data: got %h want beef", ram_dout); end
    tests_run++; if (cpu_rdy !== 1'b1) begin tests_failed++; $display("FAIL dma_rd_cpu_rdy: got %b want 1", cpu_rdy); end
    next_cycle();
  endtask

  // With STARVE_LIMIT = 8, cycles 9 and 18 of a held request are steals.
  task automatic test_starvation();
    logic exp_steal;
    idle_inputs();
    cpu_sel = 1'b1; cpu_addr = 12'h050;
    dma_req = 1'b1; dma_addr = 12'h060;
    for (int i = 1; i <= 18; i++) begin
      exp_steal = (i % 9 == 0);
      @(negedge clk);
      tests_run++; if (dma_gnt !== exp_steal) begin tests_failed++; $display("FAIL starve_gnt_c%0d: got %b want %b", i, dma_gnt, exp_steal); end
      tests_run++; if (cpu_rdy !== !exp_steal) begin tests_failed++; $display("FAIL starve_rdy_c%0d: got %b want %b", i, cpu_rdy, !exp_steal); end
      tests_run++; if (ram_addr !== (exp_steal ? 12'h060 : 12'h050)) begin tests_failed++; $display("FAIL starve_addr_c%0d: got %h", i, ram_addr); end
      if (i == 8) begin
        tests_run++; if (dut.wait_cnt !== 8'd7) begin tests_failed++; $display("FAIL starve_cnt_c8: got %0d want 7", dut.wait_cnt); end
      end
      if (i == 10) begin
        tests_run++; if (dut.wait_cnt !== 8'd0) begin tests_failed++; $display("FAIL starve_cnt_c10: got %0d want 0", dut.wait_cnt); end
        tests_run++; if (dma_rvalid !== 1'b1) begin tests_failed++; $display("FAIL starve_dma_rv_c10: got %b want 1", dma_rvalid); end
        tests_run++; if (cpu_rvalid !== 1'b0) begin tests_failed++; $display("FAIL starve_cpu_rv_c10: got %b want 0", cpu_rvalid); end
      end
      if (i == 11) begin
        tests_run++; if (cpu_rvalid !== 1'b1) begin tests_failed++; $display("FAIL starve_cpu_rv_c11: got %b want 1", cpu_rvalid); end
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_write_suppress();
    idle_inputs();
    // Plain CPU write establishes the original contents of 0x010.
    cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h010; cpu_wdata = 16'hAAAA;
    next_cycle();
    cpu_we = 1'b0; cpu_addr = 12'h050;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 12'h020; dma_wdata = 16'h2222;
    repeat (8) next_cycle();
    // Steal cycle: the CPU presents a write that must not land.
    cpu_we = 1'b1; cpu_addr = 12'h010; cpu_wdata = 16'h1111;
    @(negedge clk);
    tests_run++; if (cpu_rdy !== 1'b0) begin tests_failed++; $display("FAIL wsup_rdy: got %b want 0", cpu_rdy); end
    tests_run++; if (ram_addr !== 12'h020) begin tests_failed++; $display("FAIL wsup_addr: got %h want 020", ram_addr); end
    tests_run++; if (ram_din !== 16'h2222) begin tests_failed++; $display("FAIL wsup_din: got %h want 2222", ram_din); end
    next_cycle();
    dma_req = 1'b0; dma_we = 1'b0;
    @(negedge clk);
    tests_run++; if (mem[12'h010] !== 16'hAAAA) begin tests_failed++; $display("FAIL wsup_cpu_suppressed: got %h want aaaa", mem[12'h010]); end
    tests_run++; if (mem[12'h020] !== 16'h2222) begin tests_failed++; $display("FAIL wsup_dma_written: got %h want 2222", mem[12'h020]); end
    tests_run++; if (cpu_rdy !== 1'b1) begin tests_failed++; $display("FAIL wsup_retry_rdy: got %b want 1", cpu_rdy); end
    tests_run++; if (ram_we !== 1'b1) begin tests_failed++; $display("FAIL wsup_retry_we: got %b want 1", ram_we); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    tests_run++; if (mem[12'h010] !== 16'h1111) begin tests_failed++; $display("FAIL wsup_retry_commit: got %h want 1111", mem[12'h010]); end
    next_cycle();
  endtask

  task automatic test_interleaved();
    idle_inputs();
    cpu_sel = 1'b1; cpu_addr = 12'h010;
    next_cycle();
    cpu_sel = 1'b0; cpu_addr = 12'h7FF;
    dma_req = 1'b1; dma_addr = 12'h020;
    @(negedge clk);
    tests_run++; if (dma_gnt !== 1'b1) begin tests_failed++; $display("FAIL ilv_gnt: got %b want 1", dma_gnt); end
    tests_run++; if ({cpu_rvalid, dma_rvalid} !== 2'b10) begin tests_failed++; $display("FAIL ilv_rv1: got %b want 10", {cpu_rvalid, dma_rvalid}); end
    tests_run++; if (ram_dout !== 16'h1111) begin tests_failed++; $display("FAIL ilv_cpu_data: got %h want 1111", ram_dout); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    tests_run++; if ({cpu_rvalid, dma_rvalid} !== 2'b01) begin tests_failed++; $display("FAIL ilv_rv2: got %b want 01", {cpu_rvalid, dma_rvalid}); end
    tests_run++; if (ram_dout !== 16'h2222) begin tests_failed++; $display("FAIL ilv_dma_data: got %h want 2222", ram_dout); end
    next_cycle();
  endtask

  task automatic test_reset_steal();
    idle_inputs();
    cpu_sel = 1'b1; cpu_addr = 12'h050;
    dma_req = 1'b1; dma_addr = 12'h060;
    repeat (8) next_cycle();
    reset = 1'b1;
    @(negedge clk);
    tests_run++; if (cpu_rdy !== 1'b0) begin tests_failed++; $display("FAIL rst_steal_pre_rdy: got %b want 0", cpu_rdy); end
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    tests_run++; if (cpu_rdy !== 1'b1) begin tests_failed++; $display("FAIL rst_steal_rdy: got %b want 1", cpu_rdy); end
    tests_run++; if (dut.wait_cnt !== 8'd0) begin tests_failed++; $display("FAIL rst_steal_cnt: got %0d want 0", dut.wait_cnt); end
    tests_run++; if ({cpu_rvalid, dma_rvalid} !== 2'b00) begin tests_failed++; $display("FAIL rst_steal_rv: got %b want 00", {cpu_rvalid, dma_rvalid}); end
    next_cycle();
  endtask

  task automatic test_dropped(input logic we);
    idle_inputs();
    cpu_sel = 1'b1; cpu_addr = 12'h050;
    dma_req = 1'b1; dma_we = we; dma_addr = 12'h030; dma_wdata = 16'h5A5A;
    repeat (8) next_cycle();
    dma_req = 1'b0;
    cpu_we = 1'b1; cpu_wdata = 16'h0F0F;
    @(negedge clk);
    tests_run++; if (cpu_rdy !== 1'b0) begin tests_failed++; $display("FAIL drop_we%b_rdy: got %b want 0", we, cpu_rdy); end
    tests_run++; if (dma_gnt !== 1'b0) begin tests_failed++; $display("FAIL drop_we%b_gnt: got %b want 0", we, dma_gnt); end
    tests_run++; if (ram_we !== 1'b0) begin tests_failed++; $display("FAIL drop_we%b_ram_we: got %b want 0", we, ram_we); end
    next_cycle();
    cpu_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests_run++; if (cpu_rdy !== 1'b1) begin tests_failed++; $display("FAIL drop_we%b_no_resteal_c%0d: got %b want 1", we, i, cpu_rdy); end
      if (i == 0) begin
        tests_run++; if (dma_rvalid !== 1'b0) begin tests_failed++; $display("FAIL drop_we%b_rvalid: got %b want 0", we, dma_rvalid); end
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_dma_only();
    test_starvation();
    test_write_suppress();
    test_interleaved();
    test_reset_steal();
    test_dropped(1'b0);
    test_dropped(1'b1);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-master arbiter for the single-port on-chip block RAM (ram4k) in the 65Org16 system-on-chip. It shares the RAM between the CPU and a secondary DMA-style requester, such as an i2c loader. The CPU has priority. The DMA port uses idle RAM cycles and, after a bounded wait, steals one cycle by dropping the CPU's RDY. The block also replaces the top-level "ram read data valid" register with per-master read-valid strobes.

## Interface

- ADDR_W, 12: RAM word-address width.
- DATA_W, 16: data width (`bytesize`).
- STARVE_LIMIT, 8: consecutive denied DMA cycles before a forced steal; legal range 1..255.

- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- cpu_sel  in  1  CPU address decodes to RAM this cycle.
- cpu_we  in  1  CPU write strobe.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdy  out  1  RDY to the CPU core; low stalls the CPU.
- cpu_rvalid  out  1  ram_dout holds the CPU's read data this cycle.
- dma_req  in  1  DMA access request; held until granted.
- dma_we  in  1  DMA write strobe.
- dma_addr  in  ADDR_W  DMA word address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_gnt  out  1  DMA access is performed at the end of this cycle.
- dma_rvalid  out  1  ram_dout holds the DMA's read data this cycle.
- ram_we  out  1  to ram4k We.
- ram_addr  out  ADDR_W  to ram4k Waddr/Raddr.
- ram_din  out  DATA_W  to ram4k Din.
- ram_dout  in  DATA_W  from ram4k Dout (registered, 1-cycle latency).

## Operation

- **Internal state:**
  - steal_r, 1 bit.
  - wait_cnt, 8 bits, saturating at STARVE_LIMIT.
  - cpu_rv_r, dma_rv_r.
- **Owner selection** (combinational from state and inputs):
  - If steal_r = 1: owner is DMA. This holds even if cpu_sel = 1.
  - Else if cpu_sel = 1: owner is CPU.
  - Else if dma_req = 1: owner is DMA.
  - Else: no owner.
- **Grant and port muxing:**
  - dma_gnt = dma_req AND (owner = DMA).
  - A CPU-owned cycle drives ram_addr/ram_din/ram_we from cpu_addr/cpu_wdata/cpu_we.
  - A DMA-owned cycle drives them from dma_addr/dma_wdata/(dma_we AND dma_req).
  - With no owner, ram_we = 0 and ram_addr = cpu_addr.
- **cpu_rdy = NOT steal_r.**
  - During a steal cycle the CPU's write is suppressed; the CPU core re-presents the same bus cycle next clock.
- **Wait counter:**
  - If dma_req AND NOT dma_gnt: wait_cnt increments, saturating at STARVE_LIMIT.
  - Otherwise wait_cnt clears to 0.
- **Steal register:**
  - steal_r sets next cycle when dma_req AND NOT dma_gnt AND wait_cnt = STARVE_LIMIT-1.
  - Otherwise steal_r is 0.
  - A steal therefore lasts exactly one cycle and cannot repeat back-to-back: the stolen cycle grants the DMA and clears wait_cnt.
- **Read-valid registers:**
  - cpu_rv_r <= (owner = CPU) AND NOT cpu_we.
  - dma_rv_r <= dma_gnt AND NOT dma_we.
  - cpu_rvalid = cpu_rv_r; dma_rvalid = dma_rv_r.
- **DMA handshake:**
  - dma_req and its address/data/we must stay stable until the cycle where dma_gnt = 1.
  - The requester may present the next request in the following cycle.
  - If dma_req falls during a steal cycle, the CPU still stalls, ram_we = 0, and dma_rvalid stays 0 next cycle.

## Timing

- **Reset values:**
  - steal_r = 0 and wait_cnt = 0, so cpu_rdy = 1.
  - cpu_rvalid = 0 and dma_rvalid = 0.
  - dma_gnt and ram_we follow the combinational rules: 0 unless requested.
- **Reset mid-steal:** cpu_rdy returns to 1 in the cycle after reset is sampled.
- **Latencies:**
  - Grant is same-cycle (combinational).
  - Write commits at the clock edge ending the grant cycle.
  - Read data and rvalid appear one cycle after the grant.
- **Worst-case DMA latency:** STARVE_LIMIT+1 cycles from dma_req to dma_gnt.
- **CPU throughput loss:** at most 1 cycle per STARVE_LIMIT+1 cycles.
- **Simultaneous events:**
  - cpu_sel, dma_req, steal_r = 0: CPU wins.
  - steal_r = 1: DMA wins regardless of cpu_sel.
- **Back-to-back reads:**
  - CPU read then DMA read in consecutive cycles gives cpu_rvalid then dma_rvalid in consecutive cycles.
  - The two rvalids are never both 1.

## Test plan

- **DMA-only access:** after reset, cpu_sel = 0, DMA writes 16'hBEEF to 0x123 then reads 0x123 -> dma_gnt = 1 both cycles; dma_rvalid = 1 with ram_dout = 16'hBEEF one cycle after the read grant; cpu_rdy stays 1.
- **Starvation steal:** cpu_sel = 1 continuously with CPU reads, dma_req = 1, STARVE_LIMIT = 8 -> dma_gnt = 0 for 8 cycles; cycle 9 has cpu_rdy = 0 and dma_gnt = 1; cycle 10 has cpu_rdy = 1 and wait_cnt = 0. The pattern repeats every 9 cycles while dma_req is held.
- **Write suppression:** CPU writes 16'h1111 to 0x010 during a steal cycle while DMA writes 16'h2222 to 0x020 -> RAM 0x010 is unchanged until the CPU's retried write the next cycle; 0x020 = 16'h2222.
- **Interleaved reads:** CPU read cycle, then ROM fetch with DMA read -> cpu_rvalid and dma_rvalid are one-hot on consecutive cycles with the correct data.
- **Reset during steal:** assert reset in the steal cycle -> the next cycle has cpu_rdy = 1, wait_cnt = 0, and both rvalids = 0.
- **Dropped request:** drop dma_req during the steal cycle -> ram_we = 0, dma_rvalid = 0, and there is no second steal.
